// File: rtl/addsub_arbiter_pkg.sv
// addsub_arbiter_pkg
// Shared definitions for the two-port add/subtract arbiter slice.
// Provides the default datapath width, the opcode encoding used on both
// request ports and the result-register state constants.
package addsub_arbiter_pkg;

    // Default operand/result width of the shared arithmetic core.
    localparam int ALU_W = 20;

    // Opcode encoding presented on reqN_op.
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_NEG  = 2'b10,
        OP_PASS = 2'b11
    } alu_op_e;

    // Result-register states: EMPTY has nothing to offer, FULL holds a result.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/addsub_arbiter_rr_arbiter2.sv
// rr_arbiter2
// Two-requester round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset (last grant returns to port 1)
//   req    - request vector, bit N for port N
//   enable - grants are only issued while enable is high
//   gnt    - one-hot grant vector, or zero when nothing is granted
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic last_grant;

    // Port 0 wins when it is alone or when port 1 was served last;
    // otherwise port 1 gets the grant if it is requesting.
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req[0] && (!req[1] || last_grant)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    // The pointer resets to port 1 so that port 0 wins the first tie, and
    // only moves when a grant is actually handed out.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (enable && (|gnt)) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter
// Shares one add/subtract/negate datapath between two requesters. A
// round-robin arbiter grants at most one request per cycle, the selected
// operation is computed on a single adder and captured into a result
// register that is drained through a valid/ready handshake.
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   req0_* / req1_*          - request ports: valid, ready, op, a, b
//   res_valid / res_ready    - result handshake
//   res_data                 - registered result
//   res_flag                 - carry for ADD, borrow for SUB, else 0
//   res_id                   - port that issued the held result
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_flag,
    output logic             res_id
);

    logic [0:0]       state;
    logic             can_issue;
    logic [1:0]       gnt;
    logic             grant;
    logic             sel;
    alu_op_e          sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             flag;

    assign res_valid = (state == ST_FULL);

    // A new result may be loaded when the register is empty or is being
    // drained in this same cycle; reset blocks any acceptance.
    assign can_issue = !res_valid || res_ready;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .enable (can_issue && !rst),
        .gnt    (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign grant      = |gnt;
    assign sel        = gnt[1];

    // Operand mux in front of the single arithmetic core.
    assign sel_op = alu_op_e'(sel ? req1_op : req0_op);
    assign sel_a  = sel ? req1_a : req0_a;
    assign sel_b  = sel ? req1_b : req0_b;

    // Every opcode is mapped onto one adder: SUB uses a + ~b + 1,
    // NEG uses ~a + 0 + 1 and PASS uses a + 0 + 0.
    always_comb begin
        add_x   = sel_a;
        add_y   = '0;
        add_cin = 1'b0;
        unique case (sel_op)
            OP_ADD: begin
                add_y = sel_b;
            end
            OP_SUB: begin
                add_y   = ~sel_b;
                add_cin = 1'b1;
            end
            OP_NEG: begin
                add_x   = ~sel_a;
                add_cin = 1'b1;
            end
            OP_PASS: begin
                add_x = sel_a;
            end
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    // For SUB the adder's carry-out is the inverse of the borrow.
    always_comb begin
        flag = 1'b0;
        if (sel_op == OP_ADD) begin
            flag = sum[WIDTH];
        end else if (sel_op == OP_SUB) begin
            flag = !sum[WIDTH];
        end
    end

    // Result register: a grant always loads (also back-to-back while the
    // old result drains); a drain without a grant empties the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            res_data <= '0;
            res_flag <= 1'b0;
            res_id   <= 1'b0;
        end else if (grant) begin
            state    <= ST_FULL;
            res_data <= sum[WIDTH-1:0];
            res_flag <= flag;
            res_id   <= sel;
        end else if (res_ready) begin
            state    <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter
// Self-checking bench for addsub_arbiter: a behavioural model tracks the
// expected result register and grants, a negedge process compares the DUT
// against it every cycle, and directed steps pin literal values.
module tb_addsub_arbiter;

    localparam int W = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic          req0_ready;
    logic [1:0]    req0_op = 2'b00;
    logic [W-1:0]  req0_a = '0;
    logic [W-1:0]  req0_b = '0;
    logic          req1_valid = 1'b0;
    logic          req1_ready;
    logic [1:0]    req1_op = 2'b00;
    logic [W-1:0]  req1_a = '0;
    logic [W-1:0]  req1_b = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data;
    logic          res_flag;
    logic          res_id;

    int n_compared = 0;
    int n_mismatched = 0;
    bit check_en = 1'b0;

    // Model state, reflecting the result register after the latest edge.
    logic          m_valid = 1'b0;
    logic [W-1:0]  m_data = '0;
    logic          m_flag = 1'b0;
    logic          m_id = 1'b0;
    logic          m_last = 1'b1;
    int            m_gnt_last = -1;

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_flag   (res_flag),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    // Arithmetic written directly from the opcode definitions.
    function automatic logic [W:0] model_alu(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint r;
        case (op)
            2'b00: begin
                r = longint'(a) + longint'(b);
                return {r >= (64'd1 << W), W'(r)};
            end
            2'b01: begin
                r = longint'(a) - longint'(b);
                return {a < b, W'(r)};
            end
            2'b10: begin
                r = -longint'(a);
                return {1'b0, W'(r)};
            end
            default: return {1'b0, a};
        endcase
    endfunction

    // Which port should win this cycle: -1 means no grant.
    function automatic int pick(input logic r, input logic v0, input logic v1,
                                input logic can, input logic last);
        if (r || !can) return -1;
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {W{1'b1}};
            2: return W'(1) << (W - 1);
            3: return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [1:0] op0,
                                 input logic [W-1:0] a0, input logic [W-1:0] b0,
                                 input logic v1, input logic [1:0] op1,
                                 input logic [W-1:0] a1, input logic [W-1:0] b1,
                                 input logic rr);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update on each rising edge from the inputs seen at that edge.
    always @(posedge clk) begin
        int g;
        logic [W:0] r;
        g = pick(rst, req0_valid, req1_valid, !m_valid || res_ready, m_last);
        m_gnt_last = g;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_flag = 1'b0; m_id = 1'b0; m_last = 1'b1;
        end else if (g == 0) begin
            r = model_alu(req0_op, req0_a, req0_b);
            m_valid = 1'b1; m_data = r[W-1:0]; m_flag = r[W]; m_id = 1'b0; m_last = 1'b0;
        end else if (g == 1) begin
            r = model_alu(req1_op, req1_a, req1_b);
            m_valid = 1'b1; m_data = r[W-1:0]; m_flag = r[W]; m_id = 1'b1; m_last = 1'b1;
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
    end

    // Per-cycle comparison of grants and the result register.
    always @(negedge clk) begin
        int g;
        if (check_en) begin
            g = pick(rst, req0_valid, req1_valid, !m_valid || res_ready, m_last);
            checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
            checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
            checkOutput("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
            if (m_valid) begin
                checkOutput("res_data", 32'(res_data), 32'(m_data));
                checkOutput("res_flag", {31'd0, res_flag}, {31'd0, m_flag});
                checkOutput("res_id", {31'd0, res_id}, {31'd0, m_id});
            end
        end
    end

    initial begin
        logic [W-1:0] held_data;
        // Reset and reset values.
        rst = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        checkOutput("rst_ready0", {31'd0, req0_ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_data", 32'(res_data), 32'd0);
        checkOutput("rst_id", {31'd0, res_id}, 32'd0);

        // Port 0 ADD 1 + 2.
        applyStimulus(1'b1, 2'b00, 20'h00001, 20'h00002, 1'b0, 2'b00, '0, '0, 1'b1);
        #1;
        checkOutput("add_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        checkOutput("add_data", 32'(res_data), 32'h00003);
        checkOutput("add_flag", {31'd0, res_flag}, 32'd0);
        checkOutput("add_id", {31'd0, res_id}, 32'd0);

        // Port 1 SUB cases.
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 2'b01, 20'h00000, 20'h7FFFF, 1'b1);
        tick();
        checkOutput("sub_data", 32'(res_data), 32'h80001);
        checkOutput("sub_flag", {31'd0, res_flag}, 32'd1);
        checkOutput("sub_id", {31'd0, res_id}, 32'd1);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 2'b01, 20'hFFFFF, 20'hFFFFF, 1'b1);
        tick();
        checkOutput("sub_eq_data", 32'(res_data), 32'h00000);
        checkOutput("sub_eq_flag", {31'd0, res_flag}, 32'd0);

        // NEG edge values and ADD overflow, on port 1.
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 2'b10, 20'h00000, 20'h12345, 1'b1);
        tick();
        checkOutput("neg0_data", 32'(res_data), 32'h00000);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 2'b10, 20'hFFFFF, 20'h0, 1'b1);
        tick();
        checkOutput("negm1_data", 32'(res_data), 32'h00001);
        checkOutput("negm1_flag", {31'd0, res_flag}, 32'd0);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 2'b10, 20'h80000, 20'h0, 1'b1);
        tick();
        checkOutput("negmin_data", 32'(res_data), 32'h80000);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 2'b00, 20'hFFFFF, 20'h00001, 1'b1);
        tick();
        checkOutput("addov_data", 32'(res_data), 32'h00000);
        checkOutput("addov_flag", {31'd0, res_flag}, 32'd1);

        // Continuous contention: grants alternate starting with port 0.
        applyStimulus(1'b1, 2'b01, 20'hAAAAA, 20'h55555,
                      1'b1, 2'b00, 20'h12345, 20'h11111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("rr_id", {31'd0, res_id}, 32'(i % 2));
            checkOutput("rr_data", 32'(res_data), (i % 2 == 0) ? 32'h55555 : 32'h23456);
            checkOutput("rr_valid", {31'd0, res_valid}, 32'd1);
        end

        // Stall: result held, no grants.
        res_ready = 1'b0;
        held_data = res_data;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_ready0", {31'd0, req0_ready}, 32'd0);
            checkOutput("stall_ready1", {31'd0, req1_ready}, 32'd0);
            tick();
            checkOutput("stall_data", 32'(res_data), 32'(held_data));
            checkOutput("stall_id", {31'd0, res_id}, 32'd1);
        end
        res_ready = 1'b1;
        #1;
        checkOutput("drain_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        checkOutput("drain_valid", {31'd0, res_valid}, 32'd1);
        checkOutput("drain_id", {31'd0, res_id}, 32'd0);

        // Reset with a held result and both ports requesting.
        res_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rstmid_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        rst = 1'b0;
        checkOutput("rstmid_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rstmid_data", 32'(res_data), 32'd0);
        res_ready = 1'b1;
        tick();
        checkOutput("rstmid_tie_id", {31'd0, res_id}, 32'd0);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 600; i++) begin
            if (!(req0_valid && m_gnt_last != 0) || $urandom_range(0, 9) == 0) begin
                req0_valid = ($urandom_range(0, 9) < 7);
                req0_op    = 2'($urandom);
                req0_a     = rand_operand();
                req0_b     = rand_operand();
            end
            if (!(req1_valid && m_gnt_last != 1) || $urandom_range(0, 9) == 0) begin
                req1_valid = ($urandom_range(0, 9) < 7);
                req1_op    = 2'($urandom);
                req1_a     = rand_operand();
                req1_b     = rand_operand();
            end
            res_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
